// File: rtl/pac_rr_egress.sv
// Egress stage behind a round-robin arbiter: locks onto a one-hot grant and forwards that
// source's burst through a 2-entry FIFO. Optional per-source pop counters: PAC_EGRESS_STATS_EN.
module pac_rr_egress #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          grant_i,
  input  logic [3:0]          src_valid_i,
  input  logic [4*DATA_W-1:0] src_data_i,
  input  logic [3:0]          src_last_i,
  output logic [3:0]          src_ready_o,
  output logic                m_valid_o,
  output logic [DATA_W-1:0]   m_data_o,
  output logic                m_last_o,
  output logic [1:0]          m_src_o,
  input  logic                m_ready_i,
  output logic                done_o,
  output logic                busy_o,
  input  logic [1:0]          stat_sel_i,
  output logic [CNT_W-1:0]    stat_cnt_o
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        done_q, done_d;

  logic [DATA_W-1:0] dat_q [2];
  logic              last_q [2];
  logic [1:0]        src_q [2];
  logic              wr_q, rd_q;
  logic [1:0]        cnt_q, cnt_d;

  logic        grant_1hot;
  logic [1:0]  grant_idx;
  logic        rdy, push, pop, push_last;
  logic [DATA_W-1:0] push_data;

  assign grant_1hot = (grant_i != 4'd0) && ((grant_i & (grant_i - 4'd1)) == 4'd0);

  always_comb begin
    grant_idx = 2'd0;
    case (grant_i)
      4'b0010: grant_idx = 2'd1;
      4'b0100: grant_idx = 2'd2;
      4'b1000: grant_idx = 2'd3;
      default: grant_idx = 2'd0;
    endcase
  end

  // Ready depends only on registered state, so m_ready_i/src_valid_i never reach src_ready_o.
  assign rdy       = (state_q == XFER) && (cnt_q != 2'd2);
  assign push      = rdy && src_valid_i[idx_q];
  assign push_last = src_last_i[idx_q];
  assign push_data = src_data_i[int'(idx_q)*DATA_W +: DATA_W];
  assign pop       = (cnt_q != 2'd0) && m_ready_i;
  assign done_d    = push && push_last;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // FSM: next state; grant is only looked at in IDLE, including the done cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (grant_1hot) begin
        state_d = XFER;
        idx_d   = grant_idx;
      end
      XFER: if (push && push_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    src_ready_o        = 4'd0;
    src_ready_o[idx_q] = rdy;
    busy_o             = (state_q == XFER);
  end

  assign done_o = done_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        dat_q[i]  <= '0;
        last_q[i] <= 1'b0;
        src_q[i]  <= 2'd0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        dat_q[wr_q]  <= push_data;
        last_q[wr_q] <= push_last;
        src_q[wr_q]  <= idx_q;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
    end
  end

  // Outputs are gated so an empty FIFO never shows stale payload.
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = m_valid_o ? dat_q[rd_q]  : '0;
  assign m_last_o  = m_valid_o ? last_q[rd_q] : 1'b0;
  assign m_src_o   = m_valid_o ? src_q[rd_q]  : 2'd0;

`ifdef PAC_EGRESS_STATS_EN
  logic [3:0][CNT_W-1:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (pop && (stat_q[m_src_o] != {CNT_W{1'b1}})) begin
      stat_q[m_src_o] <= stat_q[m_src_o] + CNT_W'(1);
    end
  end

  assign stat_cnt_o = stat_q[stat_sel_i];
`else
  logic unused_stat;
  assign unused_stat = ^stat_sel_i;
  assign stat_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pac_rr_egress.sv
// Scoreboard bench for pac_rr_egress: accepted beats are queued, the m_* monitor pops and compares.
module tb_pac_rr_egress;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3:0]          grant_i;
  logic [3:0]          src_valid_i;
  logic [4*DATA_W-1:0] src_data_i;
  logic [3:0]          src_last_i;
  logic [3:0]          src_ready_o;
  logic                m_valid_o;
  logic [DATA_W-1:0]   m_data_o;
  logic                m_last_o;
  logic [1:0]          m_src_o;
  logic                m_ready_i;
  logic                done_o;
  logic                busy_o;
  logic [1:0]          stat_sel_i;
  logic [CNT_W-1:0]    stat_cnt_o;

  pac_rr_egress #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .grant_i(grant_i), .src_valid_i(src_valid_i),
    .src_data_i(src_data_i), .src_last_i(src_last_i), .src_ready_o(src_ready_o),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_src_o(m_src_o),
    .m_ready_i(m_ready_i), .done_o(done_o), .busy_o(busy_o),
    .stat_sel_i(stat_sel_i), .stat_cnt_o(stat_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  bit chk_lat = 1'b0;
  logic [DATA_W+2:0] sb [$];

  // Monitor: every beat taken downstream must match the oldest accepted beat.
  always @(negedge clk) begin
    logic [DATA_W+2:0] exp_b;
    if (rst_n && m_valid_o && m_ready_i) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got src=%0d last=%0b data=%h, required none", m_src_o, m_last_o, m_data_o);
      end else begin
        exp_b = sb.pop_front();
        if ({m_src_o, m_last_o, m_data_o} !== exp_b) begin
          n_err++;
          $display("FAIL beat_order: got %h, required %h", {m_src_o, m_last_o, m_data_o}, exp_b);
        end
      end
    end
  end

  task automatic idle_inputs();
    grant_i = 4'd0; src_valid_i = 4'd0; src_data_i = '0; src_last_i = 4'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
  endtask

  // Grant src for one cycle, then offer n beats base, base+0x11, ...; last flagged on final beat.
  task automatic send_burst(input int s, input int n, input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] d;
    int t;
    grant_i = 4'd1 << s;
    @(posedge clk); #1;
    grant_i = 4'd0;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL grant_busy: busy_o=%b, required 1", busy_o);
    end
    for (int i = 0; i < n; i++) begin
      d = base + DATA_W'(i * 8'h11);
      src_valid_i[s] = 1'b1;
      src_data_i[s*DATA_W +: DATA_W] = d;
      src_last_i[s] = (i == n - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (src_ready_o[s]) break;
        if (++t > 200) begin
          n_cmp++; n_err++;
          $display("FAIL ready_timeout: src %0d beat %0d never accepted", s, i);
          break;
        end
      end
      sb.push_back({2'(s), (i == n - 1), d});
      n_acc++;
      @(posedge clk); #1;
      if (chk_lat) begin
        n_cmp++;
        if (m_valid_o !== 1'b1 || m_data_o !== d || m_src_o !== 2'(s)) begin
          n_err++;
          $display("FAIL latency: valid=%b data=%h src=%0d, required 1 %h %0d", m_valid_o, m_data_o, m_src_o, d, s);
        end
      end
    end
    src_valid_i[s] = 1'b0; src_last_i[s] = 1'b0;
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: done=%b busy=%b, required 1 0", done_o, busy_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_err++; $display("FAIL done_width: done=%b, required 0", done_o);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin @(posedge clk); t++; end
    #1;
    n_cmp++;
    if (sb.size() != 0 || m_valid_o !== 1'b0) begin
      n_err++; $display("FAIL drain: %0d beats pending, m_valid=%b, required 0 0", sb.size(), m_valid_o);
    end
  endtask

  task automatic test_reset();
    m_ready_i = 1'b1; stat_sel_i = 2'd0;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({src_ready_o, m_valid_o, m_data_o, m_last_o, m_src_o, done_o, busy_o, stat_cnt_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b v=%b d=%h l=%b s=%0d done=%b busy=%b st=%0d, required all 0",
               src_ready_o, m_valid_o, m_data_o, m_last_o, m_src_o, done_o, busy_o, stat_cnt_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if ({src_ready_o, m_valid_o, busy_o, done_o} !== '0) begin
      n_err++; $display("FAIL post_reset_idle: rdy=%b v=%b busy=%b done=%b, required 0", src_ready_o, m_valid_o, busy_o, done_o);
    end
  endtask

  task automatic test_basic();
    m_ready_i = 1'b1;
    chk_lat = 1'b1;
    send_burst(2, 3, 8'h11);
    chk_lat = 1'b0;
    drain();
  endtask

  task automatic test_backpressure();
    m_ready_i = 1'b0;
    n_acc = 0;
    fork
      send_burst(0, 4, 8'hA0);
      begin
        repeat (6) @(posedge clk); #1;
        n_cmp++;
        if (n_acc != 2 || src_ready_o !== 4'd0 || m_valid_o !== 1'b1 || m_data_o !== 8'hA0) begin
          n_err++;
          $display("FAIL backpressure_hold: acc=%0d rdy=%b v=%b d=%h, required 2 0000 1 a0", n_acc, src_ready_o, m_valid_o, m_data_o);
        end
        m_ready_i = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_grant_filter();
    m_ready_i = 1'b1;
    grant_i = 4'b0011;
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (busy_o !== 1'b0 || src_ready_o !== 4'd0) begin
      n_err++; $display("FAIL multi_hot_grant: busy=%b rdy=%b, required 0 0000", busy_o, src_ready_o);
    end
    grant_i = 4'd0;
    n_acc = 0;
    fork
      send_burst(1, 3, 8'h40);
      begin
        wait (n_acc >= 1);
        grant_i = 4'b1000;
        @(negedge clk);
        n_cmp++;
        if (src_ready_o[3] !== 1'b0) begin
          n_err++; $display("FAIL midburst_grant: src_ready_o=%b, required bit3 0", src_ready_o);
        end
      end
    join
    // Held grant for src3 is taken in the done cycle.
    n_cmp++;
    if (busy_o !== 1'b1 || src_ready_o !== 4'b1000) begin
      n_err++; $display("FAIL regrant_in_done: busy=%b rdy=%b, required 1 1000", busy_o, src_ready_o);
    end
    send_burst(3, 1, 8'h77);
    drain();
  endtask

  task automatic test_reset_flush();
    m_ready_i = 1'b0;
    grant_i = 4'b0100;
    @(posedge clk); #1;
    grant_i = 4'd0;
    src_valid_i[2] = 1'b1; src_data_i[2*DATA_W +: DATA_W] = 8'hC3;
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (m_valid_o !== 1'b1 || src_ready_o !== 4'd0) begin
      n_err++; $display("FAIL flush_setup: v=%b rdy=%b, required 1 0000", m_valid_o, src_ready_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || m_data_o !== '0) begin
      n_err++; $display("FAIL flush_async: v=%b busy=%b d=%h, required 0 0 00", m_valid_o, busy_o, m_data_o);
    end
    idle_inputs();
    @(posedge clk); #1 rst_n = 1'b1;
    m_ready_i = 1'b1;
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL flush_stale: v=%b busy=%b, required 0 0", m_valid_o, busy_o);
    end
  endtask

  task automatic test_stats();
    logic [CNT_W-1:0] exp_c;
    do_reset();
    m_ready_i = 1'b1;
    for (int k = 0; k < 300; k++) send_burst(3, 1, DATA_W'(k));
    drain();
    for (int s = 0; s < 4; s++) begin
`ifdef PAC_EGRESS_STATS_EN
      exp_c = (s == 3) ? CNT_W'(255) : CNT_W'(0);
`else
      exp_c = '0;
`endif
      stat_sel_i = 2'(s);
      #1;
      n_cmp++;
      if (stat_cnt_o !== exp_c) begin
        n_err++; $display("FAIL stat_cnt[%0d]: got %0d, required %0d", s, stat_cnt_o, exp_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_grant_filter();
    test_reset_flush();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/pac_rr_egress.md
PAC_RR_EGRESS -- requirements
Module: pac_rr_egress

Interface
REQ-001 SHALL have parameter DATA_W, default 8, beat payload width.
REQ-002 SHALL have parameter CNT_W, default 8, width of each statistics counter.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port grant_i  input  4  one-hot grant vector from arbiter core.
REQ-006 SHALL have port src_valid_i  input  4  per-source beat valid.
REQ-007 SHALL have port src_data_i  input  4*DATA_W  per-source payload; source k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port src_last_i  input  4  per-source end-of-burst flag.
REQ-009 SHALL have port src_ready_o  output  4  per-source ready; at most one bit high.
REQ-010 SHALL have port m_valid_o  output  1  downstream beat valid.
REQ-011 SHALL have port m_data_o  output  DATA_W  downstream payload.
REQ-012 SHALL have port m_last_o  output  1  downstream end-of-burst.
REQ-013 SHALL have port m_src_o  output  2  source index of current m_* beat.
REQ-014 SHALL have port m_ready_i  input  1  downstream ready.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse: burst finished, arbiter may re-grant.
REQ-016 SHALL have port busy_o  output  1  high while FSM in XFER.
REQ-017 SHALL have port stat_sel_i  input  2  selects statistics counter.
REQ-018 SHALL have port stat_cnt_o  output  CNT_W  selected counter value.

Function
REQ-019 SHALL implement FSM states IDLE and XFER; busy_o = (state==XFER).
REQ-020 In IDLE, grant_i exactly one-hot SHALL latch its index into idx and enter XFER next cycle; zero or multi-hot grant_i SHALL be ignored.
REQ-021 In XFER, grant_i changes SHALL be ignored until burst completes.
REQ-022 SHALL buffer beats in a 2-entry FIFO (data, last, src index); m_valid_o = (count!=0), m_* driven from FIFO head.
REQ-023 src_ready_o[idx] SHALL be high only in XFER with registered count<2; all other bits low; no combinational path from m_ready_i or src_valid_i to src_ready_o.
REQ-024 Push SHALL occur when src_valid_i[idx] & src_ready_o[idx]; pop when m_valid_o & m_ready_i; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-025 Latency: beat pushed into empty FIFO in cycle N SHALL appear on m_* in cycle N+1.
REQ-026 m_* SHALL hold stable while m_valid_o & !m_ready_i.
REQ-027 A push with src_last_i[idx]=1 SHALL return FSM to IDLE next cycle and assert done_o for exactly that cycle; no further pushes from idx after the last beat.
REQ-028 A new grant SHALL be accepted in the IDLE cycle where done_o is high; FIFO need not be drained first (next burst queues behind remaining beats).
REQ-029 count SHALL never exceed 2 nor underflow.

Reset
REQ-030 Reset SHALL force IDLE, idx=0, count=0, FIFO flushed (in-flight beats discarded), stats counters=0.
REQ-031 During and after reset until first grant: src_ready_o=0, m_valid_o=0, m_data_o=0, m_last_o=0, m_src_o=0, done_o=0, busy_o=0, stat_cnt_o=0.

Configuration
REQ-032 Macro PAC_EGRESS_STATS_EN defined: four CNT_W counters, counter k increments on each pop with m_src_o==k, saturating at 2^CNT_W-1; stat_cnt_o = counter[stat_sel_i].
REQ-033 Macro PAC_EGRESS_STATS_EN undefined: no counters synthesized, stat_cnt_o tied 0, ports still present.

Verification
REQ-034 grant_i=4'b0100, src2 sends 3 beats 0x11,0x22,0x33(last), m_ready_i=1 -> m_* shows them in cycles N+1..N+3 with m_src_o=2, done_o one pulse, busy_o low after.
REQ-035 m_ready_i=0, grant src0, 4 beats offered -> src_ready_o[0] drops after 2 pushes, m_data_o holds first beat; raise m_ready_i -> all 4 delivered in order.
REQ-036 grant_i=4'b0011 in IDLE -> no state change, src_ready_o=0; grant_i changed to 4'b1000 mid-burst of src1 -> ignored until src1 last beat.
REQ-037 Assert rst_n=0 with 2 beats buffered -> m_valid_o=0, busy_o=0, count 0 immediately; no stale beat emitted after release.
REQ-038 With PAC_EGRESS_STATS_EN, 300 single-beat bursts from src3, CNT_W=8 -> stat_sel_i=3 reads 255, others 0; without macro reads 0.
